// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared widths and digit-select helper for the display scanner
package disp_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 2;
    localparam int DISP_W     = NUM_DIGITS * DIGIT_W;

    // Nibble of the selected digit; digit 0 is the rightmost (lowest) nibble.
    function automatic logic [DIGIT_W-1:0] digit_sel(input logic [DISP_W-1:0] v,
                                                     input logic [SEL_W-1:0]  sel);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel == SEL_W'(i)) d = v[i*DIGIT_W +: DIGIT_W];
        end
        return d;
    endfunction
endpackage

// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - value/load inputs and scan outputs of the display scanner
interface display_scanner_if;
    import disp_pkg::*;

    logic [DISP_W-1:0]     disp_val;
    logic                  disp_load;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [SEL_W-1:0]      select;
    logic [DIGIT_W-1:0]    digit_val;
    logic                  blank;
    logic                  frame_done;
    logic                  load_ack;

    modport master (
        output disp_val, disp_load, blink_mask,
        input  select, digit_val, blank, frame_done, load_ack
    );

    modport slave (
        input  disp_val, disp_load, blink_mask,
        output select, digit_val, blank, frame_done, load_ack
    );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enabled modulo-N counter emitting a one-cycle tick on its last count
module tick_gen #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - 4-digit scan mux with frame-aligned double buffering
// Optional blinking is built only when DISP_BLINK_EN is defined.
module display_scanner
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 250
) (
    input  logic              src_clk,
    input  logic              src_rst_n,
    display_scanner_if.slave  bus
);
    logic              tick;
    logic              frame_bnd;
    logic [SEL_W-1:0]  select;
    logic [DISP_W-1:0] shadow;
    logic [DISP_W-1:0] pending;
    logic              pending_vld;
    logic              frame_done;
    logic              load_ack;

    tick_gen #(.N(REFRESH_DIV)) u_refresh (
        .clk   (src_clk),
        .rst_n (src_rst_n),
        .en    (1'b1),
        .tick  (tick)
    );

    assign frame_bnd = tick && (select == SEL_W'(NUM_DIGITS - 1));

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            select      <= '0;
            shadow      <= '0;
            pending     <= '0;
            pending_vld <= 1'b0;
            frame_done  <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            frame_done <= frame_bnd;
            load_ack   <= frame_bnd && (pending_vld || bus.disp_load);
            if (tick) select <= select + 1'b1;
            if (bus.disp_load) pending <= bus.disp_val;
            // A load landing on the boundary itself goes straight to the shadow.
            if (frame_bnd) begin
                if (bus.disp_load)    shadow <= bus.disp_val;
                else if (pending_vld) shadow <= pending;
                pending_vld <= 1'b0;
            end else if (bus.disp_load) begin
                pending_vld <= 1'b1;
            end
        end
    end

    assign bus.select     = select;
    assign bus.digit_val  = digit_sel(shadow, select);
    assign bus.frame_done = frame_done;
    assign bus.load_ack   = load_ack;

`ifdef DISP_BLINK_EN
    logic blink_wrap;
    logic blink_phase;

    tick_gen #(.N(BLINK_DIV)) u_blink (
        .clk   (src_clk),
        .rst_n (src_rst_n),
        .en    (frame_done),
        .tick  (blink_wrap)
    );

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n)      blink_phase <= 1'b0;
        else if (blink_wrap) blink_phase <= ~blink_phase;
    end

    assign bus.blank = blink_phase & bus.blink_mask[select];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^bus.blink_mask;
    assign bus.blank         = 1'b0;
`endif
endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized and directed bench for display_scanner
module tb_display_scanner;
    localparam int R  = 4;
    localparam int BD = 2;
    localparam int FRAME = 4 * R;

    logic src_clk   = 1'b0;
    logic src_rst_n = 1'b1;
    always #5 src_clk = ~src_clk;

    display_scanner_if bus();

    display_scanner #(.REFRESH_DIV(R), .BLINK_DIV(BD)) dut (
        .src_clk   (src_clk),
        .src_rst_n (src_rst_n),
        .bus       (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: cycles since reset release, committed and pending values.
    int          n;
    logic [15:0] m_shadow;
    logic [15:0] m_pend;
    bit          m_pvld;
    bit          m_fd;
    bit          m_ack;
    int          ack_cnt;
    int          m_frames;
    bit          m_phase;
    int          a0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        m_shadow = 16'h0000;
        m_pend   = 16'h0000;
        m_pvld   = 0;
        m_fd     = 0;
        m_ack    = 0;
        m_frames = 0;
        m_phase  = 0;
    endtask

    task automatic check_outs();
        int sel;
        logic [15:0] dig;
        logic        blk;
        sel = (n / R) % 4;
        dig = (m_shadow >> (4 * sel)) & 16'h000F;
`ifdef DISP_BLINK_EN
        blk = m_phase & bus.blink_mask[sel];
`else
        blk = 1'b0;
`endif
        chk("select",     16'(bus.select),     16'(sel));
        chk("digit_val",  16'(bus.digit_val),  dig);
        chk("frame_done", 16'(bus.frame_done), 16'(m_fd));
        chk("load_ack",   16'(bus.load_ack),   16'(m_ack));
        chk("blank",      16'(bus.blank),      16'(blk));
    endtask

    task automatic cycle(input bit ld, input logic [15:0] v);
        bit boundary;
        bit prev_fd;
        bus.disp_load = ld;
        bus.disp_val  = v;
        @(posedge src_clk);
        prev_fd = m_fd;
        n++;
        boundary = (n % FRAME) == 0;
        m_fd  = boundary;
        m_ack = 0;
        if (boundary) begin
            if (ld) begin
                m_shadow = v;
                m_ack    = 1;
            end else if (m_pvld) begin
                m_shadow = m_pend;
                m_ack    = 1;
            end
            m_pvld = 0;
        end else if (ld) begin
            m_pend = v;
            m_pvld = 1;
        end
        // Blink phase flips one cycle after every BD-th frame_done pulse.
        if (prev_fd) begin
            m_frames++;
            if (m_frames == BD) begin
                m_frames = 0;
                m_phase  = ~m_phase;
            end
        end
        if (m_ack) ack_cnt++;
        @(negedge src_clk);
        bus.disp_load = 1'b0;
        check_outs();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 16'($urandom));
    endtask

    task automatic to_phase(input int p);
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != p; i++) cycle(1'b0, 16'($urandom));
    endtask

    initial begin
        bus.disp_val   = 16'h0000;
        bus.disp_load  = 1'b0;
        bus.blink_mask = 4'b0101;
        ack_cnt        = 0;
        model_reset();

        #1 src_rst_n = 1'b0;
        @(negedge src_clk);
        @(negedge src_clk);
        check_outs();
        src_rst_n = 1'b1;
        model_reset();

        idle(40);

        to_phase(5);
        a0 = ack_cnt;
        cycle(1'b1, 16'h1234);
        idle(FRAME);
        chk("ack_1234", 16'(ack_cnt - a0), 16'd1);
        idle(FRAME);

        to_phase(2);
        a0 = ack_cnt;
        cycle(1'b1, 16'h1111);
        cycle(1'b1, 16'h5959);
        idle(FRAME);
        chk("ack_last_wins", 16'(ack_cnt - a0), 16'd1);
        idle(FRAME);

        to_phase(FRAME - 1);
        a0 = ack_cnt;
        cycle(1'b1, 16'h0807);
        chk("bypass_val", 16'(bus.digit_val), 16'h0007);
        idle(2 * FRAME);
        chk("ack_bypass", 16'(ack_cnt - a0), 16'd1);

        for (int i = 0; i < 300; i++) cycle(($urandom % 8) == 0, 16'($urandom));

        to_phase(R + 2);
        cycle(1'b1, 16'hBEEF);
        #2 src_rst_n = 1'b0;
        #1;
        chk("rst_select",     16'(bus.select),     16'd0);
        chk("rst_digit_val",  16'(bus.digit_val),  16'd0);
        chk("rst_frame_done", 16'(bus.frame_done), 16'd0);
        chk("rst_load_ack",   16'(bus.load_ack),   16'd0);
        chk("rst_blank",      16'(bus.blank),      16'd0);
        @(negedge src_clk);
        @(negedge src_clk);
        src_rst_n = 1'b1;
        model_reset();
        a0 = ack_cnt;
        idle(3 * FRAME);
        chk("no_ack_after_rst", 16'(ack_cnt - a0), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Upstream driver for the 7-segment stage: time-multiplexes a 4-digit BCD display value onto the stage's `select`/`digit_val` inputs.
- Generates the digit refresh rate from the system clock.
- Double-buffers the display value so it only changes at a scan-frame boundary, which prevents tearing.
- Reports frame completion and load commit to the clock/time-keeping logic.

Parameters:
- REFRESH_DIV, 50000, src_clk cycles per digit slot (100 MHz -> 2 kHz digit rate, 500 Hz frame rate); legal range >= 2.
- BLINK_DIV, 250, frames per blink half-period (used only with DISP_BLINK_EN).

Ports:
- src_clk  in  1  system clock, all logic on rising edge.
- src_rst_n  in  1  asynchronous, active-low reset.
- disp_val  in  16  four BCD digits; [3:0] = digit 0 (rightmost, select 0), [15:12] = digit 3.
- disp_load  in  1  single-cycle request to commit disp_val to the display.
- blink_mask  in  4  per-digit blink enable (bit n -> digit n).
- select  out  2  active digit index, registered.
- digit_val  out  4  BCD nibble of the active digit.
- blank  out  1  active digit must be suppressed this slot.
- frame_done  out  1  one-cycle pulse at each frame boundary.
- load_ack  out  1  one-cycle pulse when a pending value is committed to the shadow register.

Behaviour:
- Reset values (src_rst_n low, asynchronous):
  - prescaler = 0, select = 0, shadow = 16'h0000, pending = 0, pending_vld = 0.
  - frame_done = 0, load_ack = 0, blank = 0, blink counter = 0, blink_phase = 0 (on).
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - `tick` is asserted in the cycle where prescaler == REFRESH_DIV-1.
- Select:
  - On tick, select <= select + 1, wrapping 3 -> 0. Otherwise held.
- Frame boundary:
  - Defined as tick with select == 3.
  - frame_done is registered high in the following cycle, i.e. the cycle in which select first reads 0.
- Load capture:
  - disp_load high -> pending <= disp_val, pending_vld <= 1.
  - Multiple loads before a boundary: the last one wins.
- Commit:
  - At a frame boundary with pending_vld = 1: shadow <= pending, pending_vld <= 0, load_ack pulses in the same cycle as frame_done.
  - With pending_vld = 0 at the boundary: shadow holds and load_ack stays 0.
- Simultaneous disp_load and frame boundary:
  - disp_val from that cycle bypasses straight into shadow.
  - pending_vld ends at 0 and load_ack pulses.
- digit_val:
  - Combinational mux of shadow[4*select +: 4] from registered state only; there is no path from any input.
  - Changes on the same edge as select.
- Values outside BCD (A-F) pass through unmodified; the downstream decoder handles them.
- Reset mid-frame: the scan restarts at select 0, and any uncommitted pending value is discarded.
- Latency: from disp_load to the value being visible is at most 4*REFRESH_DIV + 1 cycles.

Optional Feature:
- Macro: DISP_BLINK_EN.
- Defined:
  - A blink counter increments on every frame_done and wraps at BLINK_DIV-1.
  - On wrap, blink_phase toggles.
  - blank = blink_phase & blink_mask[select], registered alongside select.
- Undefined:
  - blank is tied to 0 and blink_mask is ignored.
  - No blink counter or blink_phase logic is instantiated.

Decomposition:
- Shared package `disp_pkg`:
  - NUM_DIGITS = 4, DIGIT_W = 4, SEL_W = 2.
  - DISP_W = NUM_DIGITS*DIGIT_W.
- One sub-module, `tick_gen`:
  - Parameterised modulo-N prescaler producing a single-cycle `tick`.
  - Reused for the refresh prescaler and the blink counter (with the blink counter's enable = frame_done).

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
- Reset, then idle 40 cycles.
  - tick every 4 cycles; select runs 0,1,2,3,0.
  - frame_done pulses every 16 cycles, coincident with select returning to 0.
  - digit_val = 0 throughout.
- Pulse disp_load with 16'h1234 mid-frame.
  - digit_val unchanged until the next boundary.
  - At the boundary, load_ack and frame_done pulse together.
  - The next frame shows 4,3,2,1 for select 0..3.
- Pulse disp_load with 16'h1111, then 16'h5959, in the same frame.
  - Exactly one load_ack at the boundary.
  - The frame shows 9,5,9,5.
- Assert disp_load with 16'h0807 in the exact boundary cycle.
  - The next frame immediately shows 7,0,8,0.
  - load_ack pulses once.
  - pending_vld = 0 afterwards.
- Assert src_rst_n low asynchronously mid-slot with a pending value outstanding.
  - All outputs clear immediately, without waiting for a clock edge.
  - After release, the pending value is never committed (no load_ack).
- DISP_BLINK_EN defined, blink_mask = 4'b0101.
  - blank is high only for select 0 and 2, during frames 2-3, 6-7, ...
  - blank stays 0 for select 1 and 3.
  - With the macro undefined, blank stays 0 always.
